// File: rtl/aes128_key_expand.sv
// AES-128 key schedule: expands one cipher key into rk0..rk10 (one round key per
// clock) and serves them through a registered random-access read port.
// Optional macro AES_KEY_CACHE_EN: a restart with the already-expanded key completes at once.
module aes128_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         ready,
    output logic [3:0]   round_count_out,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         cache_hit
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     round_reg, round_next;
    logic [127:0]   rk_reg [0:10];
    logic [127:0]   rk_data_reg;
    logic           load_key;
    logic           hit;

    logic [3:0]     prev_idx;
    logic [127:0]   prev_rk;
    logic [127:0]   new_rk;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    temp_word;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as x^254 (GF(2^8) inverse, 0 maps to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gf_mul(x, x);
        r  = sq;
        for (int i = 2; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        prev_idx = (round_reg == 4'd0) ? 4'd0 : round_reg - 4'd1;
        prev_rk  = rk_reg[prev_idx];
        rot_word = {prev_rk[23:0], prev_rk[31:24]};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        temp_word        = sub_word ^ {rcon(round_reg), 24'h000000};
        new_rk[127:96]   = prev_rk[127:96] ^ temp_word;
        new_rk[95:64]    = prev_rk[95:64]  ^ new_rk[127:96];
        new_rk[63:32]    = prev_rk[63:32]  ^ new_rk[95:64];
        new_rk[31:0]     = prev_rk[31:0]   ^ new_rk[63:32];
    end

`ifdef AES_KEY_CACHE_EN
    logic cache_hit_reg;

    // In DONE rk0 is exactly the last fully expanded key, so it doubles as the cache tag.
    assign hit = (state_reg == DONE) && start && (key == rk_reg[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_hit_reg <= 1'b0;
        end else begin
            cache_hit_reg <= hit;
        end
    end

    assign cache_hit = cache_hit_reg;
`else
    assign hit       = 1'b0;
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        load_key   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = EXPAND;
                    round_next = 4'd1;
                    load_key   = 1'b1;
                end
            end
            EXPAND: begin
                if (round_reg == 4'd10) begin
                    state_next = DONE;
                end else begin
                    round_next = round_reg + 4'd1;
                end
            end
            DONE: begin
                if (start && !hit) begin
                    state_next = EXPAND;
                    round_next = 4'd1;
                    load_key   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                round_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            round_reg   <= 4'd0;
            rk_data_reg <= '0;
            for (int i = 0; i < 11; i++) begin
                rk_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            if (load_key) begin
                rk_reg[0] <= key;
            end else if (state_reg == EXPAND) begin
                rk_reg[round_reg] <= new_rk;
            end
            rk_data_reg <= (rk_addr <= 4'd10) ? rk_reg[rk_addr] : '0;
        end
    end

    assign busy            = (state_reg == EXPAND);
    assign ready           = (state_reg == DONE);
    assign round_count_out = round_reg;
    assign rk_data         = rk_data_reg;

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand against a word-oriented key-schedule model
// whose S-box is derived by brute-force GF(2^8) inversion.
module tb_aes128_key_expand;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         ready;
    logic [3:0]   round_count_out;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         cache_hit;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] model_rk [0:10];

    aes128_key_expand dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .key             (key),
        .busy            (busy),
        .ready           (ready),
        .round_count_out (round_count_out),
        .rk_addr         (rk_addr),
        .rk_data         (rk_data),
        .cache_hit       (cache_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic pulse_start(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
        rk_addr = a;
        @(posedge clk); #1;
        d = rk_data;
    endtask

    task automatic wait_ready(input int budget, output int cyc);
        cyc = 0;
        while (!ready && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!ready) cyc = -1;
    endtask

    task automatic wait_rco(input logic [3:0] val, input int budget, output bit found);
        int n;
        n = 0;
        while (round_count_out !== val && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        found = (round_count_out === val);
    endtask

    task automatic test_reset();
        logic [127:0] d;
        rst_n = 1'b0; start = 1'b1; key = rand_key(); rk_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (round_count_out !== 4'd0) begin errors++; $display("FAIL reset_rco got %0d exp 0", round_count_out); end
        checks++; if (rk_data !== 128'h0) begin errors++; $display("FAIL reset_rk_data got %h exp 0", rk_data); end
        checks++; if (cache_hit !== 1'b0) begin errors++; $display("FAIL reset_cache_hit got %b exp 0", cache_hit); end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b exp 0", busy); end
        for (int a = 0; a < 11; a++) begin
            read_rk(4'(a), d);
            checks++; if (d !== 128'h0) begin errors++; $display("FAIL reset_rk%0d got %h exp 0", a, d); end
        end
    endtask

    task automatic test_fips_vector();
        logic [127:0] k;
        logic [127:0] d;
        bit           bad;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(k);
        pulse_start(k);
        checks++; if ({busy, ready, round_count_out} !== {1'b1, 1'b0, 4'd1}) begin
            errors++; $display("FAIL accept_edge got busy=%b ready=%b rco=%0d exp 1 0 1", busy, ready, round_count_out);
        end
        bad = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n < 10 && (ready !== 1'b0 || busy !== 1'b1 || round_count_out !== 4'(n + 1))) bad = 1'b1;
            if (n == 10 && (ready !== 1'b1 || busy !== 1'b0 || round_count_out !== 4'd10)) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL fips_latency got ready=%b busy=%b rco=%0d exp ready on 10th edge", ready, busy, round_count_out); end
        read_rk(4'd1, d);
        checks++; if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin errors++; $display("FAIL fips_rk1 got %h exp a0fafe1788542cb123a339392a6c7605", d); end
        read_rk(4'd10, d);
        checks++; if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fips_rk10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", d); end
        for (int a = 10; a >= 0; a--) begin
            read_rk(4'(a), d);
            checks++; if (d !== model_rk[a]) begin errors++; $display("FAIL fips_model_rk%0d got %h exp %h", a, d, model_rk[a]); end
        end
    endtask

    task automatic test_vector2();
        logic [127:0] k;
        logic [127:0] d;
        int           cyc;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        pulse_start(k);
        wait_ready(20, cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL vec2_latency got %0d exp 10", cyc); end
        read_rk(4'd0, d);
        checks++; if (d !== k) begin errors++; $display("FAIL vec2_rk0 got %h exp %h", d, k); end
        read_rk(4'd10, d);
        checks++; if (d !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("FAIL vec2_rk10 got %h exp 13111d7fe3944a17f307a78b4d2b30c5", d); end
        for (int a = 11; a < 16; a++) begin
            read_rk(4'(a), d);
            checks++; if (d !== 128'h0) begin errors++; $display("FAIL addr%0d_zero got %h exp 0", a, d); end
        end
    endtask

    task automatic test_ignore_start();
        logic [127:0] k1;
        logic [127:0] k2;
        logic [127:0] d;
        bit           found;
        int           cyc;
        k1 = rand_key();
        k2 = ~k1;
        model_expand(k1);
        pulse_start(k1);
        wait_rco(4'd5, 20, found);
        checks++; if (!found) begin errors++; $display("FAIL ignore_reach_rco5 got %0d exp 5", round_count_out); end
        pulse_start(k2);
        checks++; if (round_count_out !== 4'd6 || busy !== 1'b1) begin
            errors++; $display("FAIL ignore_busy_start got rco=%0d busy=%b exp 6 1", round_count_out, busy);
        end
        wait_ready(20, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL ignore_remaining got %0d exp 5", cyc); end
        read_rk(4'd10, d);
        checks++; if (d !== model_rk[10]) begin errors++; $display("FAIL ignore_rk10 got %h exp %h", d, model_rk[10]); end
        read_rk(4'd0, d);
        checks++; if (d !== k1) begin errors++; $display("FAIL ignore_rk0 got %h exp %h", d, k1); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        bit           found;
        bit           bad;
        pulse_start(rand_key());
        wait_rco(4'd6, 20, found);
        checks++; if (!found) begin errors++; $display("FAIL midrst_reach_rco6 got %0d exp 6", round_count_out); end
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        checks++; if ({busy, ready, round_count_out} !== {1'b0, 1'b0, 4'd0}) begin
            errors++; $display("FAIL midrst_async got busy=%b ready=%b rco=%0d exp 0 0 0", busy, ready, round_count_out);
        end
        checks++; if (rk_data !== 128'h0) begin errors++; $display("FAIL midrst_rk_data got %h exp 0", rk_data); end
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL midrst_stays_idle got ready=%b busy=%b exp 0 0", ready, busy); end
        for (int a = 0; a < 11; a++) begin
            read_rk(4'(a), d);
            checks++; if (d !== 128'h0) begin errors++; $display("FAIL midrst_rk%0d got %h exp 0", a, d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k1;
        logic [127:0] k2;
        logic [127:0] d;
        logic [3:0]   a;
        int           cyc;
        bit           bad;
        k1 = rand_key();
        k2 = rand_key();
        if (k2 == k1) k2[0] = ~k2[0];
        pulse_start(k1);
        wait_ready(20, cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL b2b_first_latency got %0d exp 10", cyc); end
        model_expand(k2);
        pulse_start(k2);
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_ready_drop got ready=%b busy=%b exp 0 1", ready, busy); end
        bad = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (ready !== (n == 10)) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL b2b_latency got ready=%b exp ready exactly on 10th edge", ready); end
        read_rk(4'd10, d);
        checks++; if (d !== model_rk[10]) begin errors++; $display("FAIL b2b_rk10 got %h exp %h", d, model_rk[10]); end
        repeat (3) begin
            a = 4'($urandom_range(0, 10));
            read_rk(a, d);
            checks++; if (d !== model_rk[a]) begin errors++; $display("FAIL b2b_rk%0d got %h exp %h", a, d, model_rk[a]); end
        end
    endtask

    // Relies on the previous test leaving the block in DONE with model_rk holding its key.
    task automatic test_same_key();
        logic [127:0] d;
`ifdef AES_KEY_CACHE_EN
        pulse_start(model_rk[0]);
        checks++; if ({cache_hit, busy, ready} !== 3'b101) begin
            errors++; $display("FAIL cache_hit_edge got hit=%b busy=%b ready=%b exp 1 0 1", cache_hit, busy, ready);
        end
        @(posedge clk); #1;
        checks++; if ({cache_hit, busy, ready} !== 3'b001) begin
            errors++; $display("FAIL cache_hit_pulse got hit=%b busy=%b ready=%b exp 0 0 1", cache_hit, busy, ready);
        end
`else
        int cyc;
        pulse_start(model_rk[0]);
        checks++; if ({cache_hit, busy, ready} !== 3'b010) begin
            errors++; $display("FAIL same_key_reexpand got hit=%b busy=%b ready=%b exp 0 1 0", cache_hit, busy, ready);
        end
        wait_ready(20, cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL same_key_latency got %0d exp 10", cyc); end
`endif
        read_rk(4'd10, d);
        checks++; if (d !== model_rk[10]) begin errors++; $display("FAIL same_key_rk10 got %h exp %h", d, model_rk[10]); end
    endtask

    task automatic test_random_keys();
        logic [127:0] k;
        logic [127:0] d;
        int           cyc;
        for (int t = 0; t < 3; t++) begin
            k = rand_key();
            model_expand(k);
            pulse_start(k);
            wait_ready(20, cyc);
            checks++; if (cyc != 10) begin errors++; $display("FAIL rand%0d_latency got %0d exp 10", t, cyc); end
            for (int a = 0; a < 11; a++) begin
                read_rk(4'(a), d);
                checks++; if (d !== model_rk[a]) begin errors++; $display("FAIL rand%0d_rk%0d got %h exp %h", t, a, d, model_rk[a]); end
            end
            read_rk(4'($urandom_range(11, 15)), d);
            checks++; if (d !== 128'h0) begin errors++; $display("FAIL rand%0d_oob got %h exp 0", t, d); end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        key     = '0;
        rk_addr = 4'd0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_vector2();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_same_key();
        test_random_keys();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
